// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display path: segment patterns and scan-capture FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Segment vectors are active-low, ordered {a,b,c,d,e,f,g} = bit6..bit0.
// The forward BCD-to-segment driver and the scan capture reader both use these patterns,
// so the two directions of the display path always agree.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001101;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Code reported for any pattern that is not one of the ten digits.
    localparam logic [3:0] CODE_INVALID = 4'hF;

    // COLLECT: gathering digits for the next frame, nothing offered downstream.
    // PRESENT: a frame is held on the outputs with frame_valid high.
    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps one active-low 7-segment pattern to its BCD code and flags anything that is not a digit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input continuously.
//
// Ports:
//   seg_n_i    7-bit active-low segment pattern {a,b,c,d,e,f,g}
//   code_o     BCD code 0..9, or 4'hF when the pattern is not a digit
//   invalid_o  high when the pattern is not one of the ten digits (blank included)
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] code_o,
    output logic       invalid_o
);

    always_comb begin
        code_o    = CODE_INVALID;
        invalid_o = 1'b0;
        case (seg_n_i)
            SEG_0:   code_o = 4'd0;
            SEG_1:   code_o = 4'd1;
            SEG_2:   code_o = 4'd2;
            SEG_3:   code_o = 4'd3;
            SEG_4:   code_o = 4'd4;
            SEG_5:   code_o = 4'd5;
            SEG_6:   code_o = 4'd6;
            SEG_7:   code_o = 4'd7;
            SEG_8:   code_o = 4'd8;
            SEG_9:   code_o = 4'd9;
            default: begin
                code_o    = CODE_INVALID;
                invalid_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Recovers the BCD value of each digit of a multiplexed 7-segment bus and delivers whole frames.
// Latency: capture STABLE_CYCLES edges after a value reaches the input register; frame_valid one edge later.
// Backpressure: frame held stable until frame_ready; a frame completing while one is held is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   seg_n         active-low segments {a,b,c,d,e,f,g}
//   an_n          active-low digit anodes, an_n[i] selects digit i
//   digits_o      frame data, digit i in bits [4i+3:4i]
//   frame_valid   frame available on digits_o / frame_err
//   frame_ready   consumer accepts when frame_valid && frame_ready
//   frame_err     frame contains at least one non-digit pattern
//   overrun       sticky: a completed frame was discarded under back-pressure
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // ------------------------------------------------------------------
    // Input stage: one register on the bus plus a copy of the previous
    // sample, so the dwell counter compares two registered values.
    // ------------------------------------------------------------------
    logic [6:0]            seg_q, seg_prev_q;
    logic [NUM_DIGITS-1:0] an_q, an_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q      <= '1;
            seg_prev_q <= '1;
            an_q       <= '1;
            an_prev_q  <= '1;
        end else begin
            seg_q      <= seg_n;
            seg_prev_q <= seg_q;
            an_q       <= an_n;
            an_prev_q  <= an_q;
        end
    end

    // ------------------------------------------------------------------
    // Pattern decode of the registered sample
    // ------------------------------------------------------------------
    logic [3:0] code;
    logic       code_invalid;

    seg7_pattern_decode u_decode (
        .seg_n_i   (seg_q),
        .code_o    (code),
        .invalid_o (code_invalid)
    );

    // ------------------------------------------------------------------
    // Anode qualification: only a sample with exactly one active anode
    // belongs to a digit. an_act doubles as the one-hot digit select.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] an_act;
    logic                  eligible;
    logic                  same_sample;

    assign an_act      = ~an_q;
    assign eligible    = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
    assign same_sample = (seg_q == seg_prev_q) && (an_q == an_prev_q);

    // ------------------------------------------------------------------
    // Dwell counter. Saturation at CNT_MAX makes the "becomes CNT_MAX"
    // condition true exactly once per uninterrupted dwell.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

    always_comb begin
        cnt_d = '0;
        if (eligible) begin
            if (!same_sample) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign capture = eligible && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly: working nibbles, per-digit seen mask, error accumulator
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][3:0] work_q, work_d;
    logic [NUM_DIGITS-1:0]      seen_q, seen_d;
    logic                       err_acc_q, err_acc_d;
    logic                       frame_full;

    assign frame_full = &seen_q;

    // A completed frame is consumed (loaded or dropped) in the cycle after
    // its last capture. A capture landing in that same cycle belongs to the
    // next frame, so it is ORed onto the cleared mask rather than lost.
    always_comb begin
        work_d    = work_q;
        seen_d    = frame_full ? '0 : seen_q;
        err_acc_d = frame_full ? 1'b0 : err_acc_q;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (an_act[i]) begin
                    work_d[i] = code;
                end
            end
            seen_d    = seen_d | an_act;
            err_acc_d = err_acc_d | code_invalid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q    <= '0;
            seen_q    <= '0;
            err_acc_q <= 1'b0;
        end else begin
            work_q    <= work_d;
            seen_q    <= seen_d;
            err_acc_q <= err_acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    scan_state_e state_q, state_d;
    logic        handshake;

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    assign handshake = frame_valid_q && frame_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (frame_full) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // A new frame arriving on the handshake cycle keeps us here
                // so frame_valid has no bubble between frames.
                if (handshake && !frame_full) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        digits_d      = digits_q;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q;
        frame_valid_d = (state_d == PRESENT);
        case (state_q)
            COLLECT: begin
                if (frame_full) begin
                    digits_d    = work_q;
                    frame_err_d = err_acc_q;
                end
            end
            PRESENT: begin
                if (frame_full) begin
                    if (handshake) begin
                        digits_d    = work_q;
                        frame_err_d = err_acc_q;
                    end else begin
                        // Held frame wins; the newer one is thrown away.
                        overrun_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign digits_o    = digits_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule
